// File: rtl/j1a_bus_bridge.sv
// j1a_bus_bridge: serialises each J1A lock-step instruction/data step into
// one or two Wishbone cycles on a single 16-bit master port, with a bus
// watchdog that substitutes zero data when the slave never acknowledges.
module j1a_bus_bridge #(
  parameter logic [1:0]  PROG_SEG = 2'b00,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        sys_clk_i,
  input  logic        sys_res_i,
  input  logic [12:0] ins_adr_i,
  input  logic        ins_cyc_i,
  output logic [15:0] ins_dat_o,
  input  logic [14:0] dat_adr_i,
  input  logic [15:0] dat_dat_i,
  output logic [15:0] dat_dat_o,
  input  logic        dat_we_i,
  input  logic        dat_cyc_i,
  input  logic        shr_stb_i,
  output logic        shr_ack_o,
  output logic [14:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, IFETCH, DECIDE, DACC, DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wd_cnt, wd_cnt_nxt;
  logic        wd_expire;
  logic [14:0] adr_nxt;
  logic [15:0] wdat_nxt, ins_nxt, dat_nxt;
  logic        we_nxt, cyc_nxt, stb_nxt, ack_nxt, err_nxt;

  // Last waiting cycle of a downstream access: the strobe has been up TIMEOUT cycles.
  assign wd_expire = (wd_cnt == WD_LAST);

  // State register.
  always_ff @(posedge sys_clk_i or negedge sys_res_i) begin
    if (!sys_res_i) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode; an acknowledge and a watchdog expiry leave a bus phase the same way.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (shr_stb_i && ins_cyc_i) state_nxt = IFETCH;
      IFETCH:  if (wb_ack_i || wd_expire) state_nxt = DECIDE;
      DECIDE:  state_nxt = dat_cyc_i ? DACC : DONE;
      DACC:    if (wb_ack_i || wd_expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output; shr_ack_o is raised on entry to DONE
  // so that it is high during the DONE cycle itself.
  always_comb begin
    adr_nxt    = wb_adr_o;
    wdat_nxt   = wb_dat_o;
    ins_nxt    = ins_dat_o;
    dat_nxt    = dat_dat_o;
    we_nxt     = wb_we_o;
    cyc_nxt    = wb_cyc_o;
    stb_nxt    = wb_stb_o;
    err_nxt    = err_o;
    ack_nxt    = 1'b0;
    wd_cnt_nxt = wd_cnt;
    case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        if (shr_stb_i && ins_cyc_i) begin
          adr_nxt = {PROG_SEG, ins_adr_i};
          we_nxt  = 1'b0;
          cyc_nxt = 1'b1;
          stb_nxt = 1'b1;
        end
      end
      IFETCH: begin
        if (wb_ack_i || wd_expire) begin
          ins_nxt = wb_ack_i ? wb_dat_i : '0;
          err_nxt = err_o | ~wb_ack_i;
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end
      DECIDE: begin
        wd_cnt_nxt = '0;
        if (dat_cyc_i) begin
          adr_nxt  = dat_adr_i;
          we_nxt   = dat_we_i;
          wdat_nxt = dat_dat_i;
          cyc_nxt  = 1'b1;
          stb_nxt  = 1'b1;
        end else begin
          ack_nxt = shr_stb_i;
        end
      end
      DACC: begin
        if (wb_ack_i || wd_expire) begin
          if (!wb_we_o) dat_nxt = wb_ack_i ? wb_dat_i : '0;
          err_nxt = err_o | ~wb_ack_i;
          we_nxt  = 1'b0;
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
          ack_nxt = shr_stb_i;
        end else begin
          wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Output and watchdog registers.
  always_ff @(posedge sys_clk_i or negedge sys_res_i) begin
    if (!sys_res_i) begin
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      ins_dat_o <= '0;
      dat_dat_o <= '0;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      shr_ack_o <= 1'b0;
      err_o     <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      wb_adr_o  <= adr_nxt;
      wb_dat_o  <= wdat_nxt;
      ins_dat_o <= ins_nxt;
      dat_dat_o <= dat_nxt;
      wb_we_o   <= we_nxt;
      wb_cyc_o  <= cyc_nxt;
      wb_stb_o  <= stb_nxt;
      shr_ack_o <= ack_nxt;
      err_o     <= err_nxt;
      wd_cnt    <= wd_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_j1a_bus_bridge.sv
// Scoreboard bench for j1a_bus_bridge: core-side steps push expected results,
// a negedge slave/monitor records every downstream Wishbone cycle.
module tb_j1a_bus_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] ins_adr_i;
  logic        ins_cyc_i;
  logic [14:0] dat_adr_i;
  logic [15:0] dat_dat_i;
  logic        dat_we_i;
  logic        dat_cyc_i;
  logic        shr_stb_i;
  logic        data_en;
  logic [15:0] wb_dat_i = 16'h0;
  logic        wb_ack_i = 1'b0;
  logic [15:0] ins_dat_o, dat_dat_o, wb_dat_o;
  logic [14:0] wb_adr_o;
  logic        shr_ack_o, wb_we_o, wb_cyc_o, wb_stb_o, err_o;
  logic [15:0] s_ins, s_dat, s_wdat;
  logic [14:0] s_adr;
  logic        s_ack, s_we, s_cyc, s_stb, s_err;

  // Slave behaviour per step (written only by the stimulus tasks)
  logic [15:0] ins_word, rd_word;
  int unsigned ins_waits, dat_waits;

  always #5 clk = ~clk;

  // Core model: data access requested for opcodes with bits [15:13] = 011
  assign dat_cyc_i = data_en && (ins_dat_o[15:13] == 3'b011);

  j1a_bus_bridge #(.PROG_SEG(2'b00), .TIMEOUT(TO)) dut (
    .sys_clk_i(clk), .sys_res_i(rst_n),
    .ins_adr_i(ins_adr_i), .ins_cyc_i(ins_cyc_i), .ins_dat_o(ins_dat_o),
    .dat_adr_i(dat_adr_i), .dat_dat_i(dat_dat_i), .dat_dat_o(dat_dat_o),
    .dat_we_i(dat_we_i), .dat_cyc_i(dat_cyc_i),
    .shr_stb_i(shr_stb_i), .shr_ack_o(shr_ack_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .err_o(err_o)
  );

  j1a_bus_bridge #(.PROG_SEG(2'b11), .TIMEOUT(TO)) u_seg (
    .sys_clk_i(clk), .sys_res_i(rst_n),
    .ins_adr_i(ins_adr_i), .ins_cyc_i(ins_cyc_i), .ins_dat_o(s_ins),
    .dat_adr_i(dat_adr_i), .dat_dat_i(dat_dat_i), .dat_dat_o(s_dat),
    .dat_we_i(dat_we_i), .dat_cyc_i(dat_cyc_i),
    .shr_stb_i(shr_stb_i), .shr_ack_o(s_ack),
    .wb_adr_o(s_adr), .wb_dat_o(s_wdat), .wb_dat_i(wb_dat_i),
    .wb_we_o(s_we), .wb_cyc_o(s_cyc), .wb_stb_o(s_stb),
    .wb_ack_i(wb_ack_i), .err_o(s_err)
  );

  typedef struct {
    logic [14:0] adr;
    logic [14:0] sadr;
    logic        we;
    logic [15:0] wdat;
    int unsigned len;
    logic        stable;
  } dn_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] dat;
    logic        err;
    int unsigned cyc;
  } sb_t;

  dn_t exp_dn[$];
  dn_t obs_dn[$];
  sb_t exp_sb[$];

  int tests_run = 0;
  int fails = 0;
  logic [15:0] model_dat = 16'h0;
  logic        model_err = 1'b0;

  // Slave + monitor
  dn_t         cur;
  logic        prev_stb = 1'b0;
  int unsigned slv_cnt = 0;
  int unsigned slv_phase = 0;
  always @(negedge clk) begin
    int unsigned w;
    if (wb_cyc_o && wb_stb_o) begin
      if (!prev_stb) begin
        cur.adr = wb_adr_o; cur.sadr = s_adr; cur.we = wb_we_o;
        cur.wdat = wb_dat_o; cur.len = 1; cur.stable = 1'b1;
      end else begin
        cur.len++;
        if (wb_adr_o !== cur.adr || wb_we_o !== cur.we || wb_dat_o !== cur.wdat)
          cur.stable = 1'b0;
      end
      w = (slv_phase == 0) ? ins_waits : dat_waits;
      if (slv_cnt == w) begin
        wb_ack_i = 1'b1;
        wb_dat_i = (slv_phase == 0) ? ins_word : rd_word;
        slv_cnt = 0;
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = 16'($urandom);
        slv_cnt++;
      end
      prev_stb = 1'b1;
    end else begin
      if (prev_stb) begin
        obs_dn.push_back(cur);
        slv_phase++;
      end
      if (!rst_n || shr_ack_o || !shr_stb_i) slv_phase = 0;
      wb_ack_i = 1'b0;
      wb_dat_i = 16'($urandom);
      slv_cnt = 0;
      prev_stb = 1'b0;
    end
  end

  task automatic drain_obs();
    while (obs_dn.size() > 0) void'(obs_dn.pop_front());
  endtask

  // One core step; iwaits/dwaits >= TO means the slave never acknowledges.
  task automatic do_step(input logic [12:0] iadr, input logic [15:0] iword,
                         input int unsigned iwaits, input logic den, input logic we,
                         input logic [14:0] dadr, input logic [15:0] wdat,
                         input logic [15:0] rword, input int unsigned dwaits);
    sb_t e, got;
    dn_t d, o;
    int unsigned ilen, dlen, k;
    logic dacc;
    ilen = (iwaits >= TO) ? TO : iwaits + 1;
    e.ins = (iwaits >= TO) ? 16'h0000 : iword;
    if (iwaits >= TO) model_err = 1'b1;
    dacc = den && (e.ins[15:13] == 3'b011);
    d.adr = {2'b00, iadr}; d.sadr = {2'b11, iadr}; d.we = 1'b0; d.wdat = '0;
    d.len = ilen; d.stable = 1'b1;
    exp_dn.push_back(d);
    dlen = 0;
    if (dacc) begin
      dlen = (dwaits >= TO) ? TO : dwaits + 1;
      if (dwaits >= TO) model_err = 1'b1;
      if (!we) model_dat = (dwaits >= TO) ? 16'h0000 : rword;
      d.adr = dadr; d.sadr = dadr; d.we = we; d.wdat = wdat; d.len = dlen;
      exp_dn.push_back(d);
    end
    e.dat = model_dat;
    e.err = model_err;
    e.cyc = 2 + ilen + dlen;
    exp_sb.push_back(e);

    @(negedge clk);
    ins_adr_i = iadr; ins_word = iword; ins_waits = iwaits;
    data_en = den; dat_we_i = we; dat_adr_i = dadr; dat_dat_i = wdat;
    rd_word = rword; dat_waits = dwaits;
    ins_cyc_i = 1'b1; shr_stb_i = 1'b1;
    k = 0;
    for (int unsigned c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (shr_ack_o) begin k = c; break; end
    end
    got = exp_sb.pop_front();
    tests_run++;
    if (k == 0) begin
      fails++;
      $display("FAIL ack_timeout: no shr_ack_o within 60 cycles, required at cycle %0d", got.cyc);
    end else begin
      tests_run += 3;
      if (k != got.cyc) begin fails++; $display("FAIL ack_cycle: got %0d required %0d", k, got.cyc); end
      if (ins_dat_o !== got.ins) begin fails++; $display("FAIL ins_dat: got %h required %h", ins_dat_o, got.ins); end
      if (dat_dat_o !== got.dat) begin fails++; $display("FAIL dat_dat: got %h required %h", dat_dat_o, got.dat); end
      if (err_o !== got.err) begin fails++; $display("FAIL err: got %b required %b", err_o, got.err); end
    end
    shr_stb_i = 1'b0; ins_cyc_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (shr_ack_o !== 1'b0) begin fails++; $display("FAIL ack_width: got %b required 0", shr_ack_o); end
    while (exp_dn.size() > 0) begin
      d = exp_dn.pop_front();
      tests_run++;
      if (obs_dn.size() == 0) begin
        fails++; $display("FAIL dn_missing: got none required cycle at %h", d.adr);
      end else begin
        o = obs_dn.pop_front();
        tests_run += 5;
        if (o.adr !== d.adr) begin fails++; $display("FAIL dn_adr: got %h required %h", o.adr, d.adr); end
        if (o.sadr !== d.sadr) begin fails++; $display("FAIL seg_adr: got %h required %h", o.sadr, d.sadr); end
        if (o.we !== d.we) begin fails++; $display("FAIL dn_we: got %b required %b", o.we, d.we); end
        if (o.len != d.len) begin fails++; $display("FAIL dn_len: got %0d required %0d", o.len, d.len); end
        if (o.stable !== 1'b1) begin fails++; $display("FAIL dn_hold: got %b required 1", o.stable); end
        if (d.we) begin
          tests_run++;
          if (o.wdat !== d.wdat) begin fails++; $display("FAIL dn_wdat: got %h required %h", o.wdat, d.wdat); end
        end
      end
    end
    tests_run++;
    if (obs_dn.size() != 0) begin
      fails++; $display("FAIL dn_extra: got %0d extra cycles required 0", obs_dn.size());
      drain_obs();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; shr_stb_i = 1'b0; ins_cyc_i = 1'b0; data_en = 1'b0;
    ins_adr_i = '0; dat_adr_i = '0; dat_dat_i = '0; dat_we_i = 1'b0;
    ins_word = '0; rd_word = '0; ins_waits = 0; dat_waits = 0;
    repeat (3) @(negedge clk);
    tests_run += 5;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, shr_ack_o, err_o} !== 5'b0)
      begin fails++; $display("FAIL rst_ctrl: got %b required 00000", {wb_cyc_o, wb_stb_o, wb_we_o, shr_ack_o, err_o}); end
    if (wb_adr_o !== 15'h0) begin fails++; $display("FAIL rst_adr: got %h required 0", wb_adr_o); end
    if (wb_dat_o !== 16'h0) begin fails++; $display("FAIL rst_wdat: got %h required 0", wb_dat_o); end
    if (ins_dat_o !== 16'h0) begin fails++; $display("FAIL rst_ins: got %h required 0", ins_dat_o); end
    if (dat_dat_o !== 16'h0) begin fails++; $display("FAIL rst_dat: got %h required 0", dat_dat_o); end
    rst_n = 1'b1;
    model_dat = '0; model_err = 1'b0;
  endtask

  task automatic test_fetch_only();
    do_step(13'h0010, 16'h8005, 0, 1'b0, 1'b0, 15'h0, 16'h0, 16'h0, 0);
  endtask

  task automatic test_load();
    do_step(13'h0011, 16'h6C00, 0, 1'b1, 1'b0, 15'h1234, 16'h0, 16'hBEEF, 0);
  endtask

  task automatic test_store_wait();
    do_step(13'h0012, 16'h6020, 0, 1'b1, 1'b1, 15'h7FFF, 16'hA5A5, 16'h1111, 3);
  endtask

  task automatic test_watchdog();
    do_step(13'h0030, 16'h6C00, 255, 1'b1, 1'b0, 15'h0100, 16'h0, 16'h2222, 0);
    do_step(13'h0031, 16'h6C00, 1, 1'b1, 1'b0, 15'h0200, 16'h0, 16'hCAFE, 2);
    do_step(13'h0032, 16'h6C00, 0, 1'b1, 1'b0, 15'h0300, 16'h0, 16'h3333, 255);
    do_step(13'h0033, 16'h6020, 2, 1'b1, 1'b1, 15'h0400, 16'h5A5A, 16'h0, 255);
  endtask

  task automatic test_prog_seg();
    do_step(13'h1FFF, 16'h8005, 0, 1'b0, 1'b0, 15'h0, 16'h0, 16'h0, 0);
  endtask

  task automatic test_back_to_back();
    do_step(13'h0040, 16'h6C00, 0, 1'b1, 1'b0, 15'h0041, 16'h0, 16'h1357, 0);
    do_step(13'h0042, 16'h8123, 1, 1'b1, 1'b0, 15'h0, 16'h0, 16'h0, 0);
  endtask

  task automatic test_stb_drop();
    logic seen;
    @(negedge clk);
    ins_adr_i = 13'h0050; ins_word = 16'h8ABC; ins_waits = 1; data_en = 1'b0;
    ins_cyc_i = 1'b1; shr_stb_i = 1'b1;
    @(negedge clk);
    shr_stb_i = 1'b0; ins_cyc_i = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (shr_ack_o) seen = 1'b1;
    end
    tests_run += 2;
    if (seen !== 1'b0) begin fails++; $display("FAIL drop_no_ack: got %b required 0", seen); end
    if (ins_dat_o !== 16'h8ABC) begin fails++; $display("FAIL drop_ins: got %h required 8abc", ins_dat_o); end
    drain_obs();
  endtask

  task automatic test_reset_mid_dacc();
    logic seen;
    @(negedge clk);
    ins_adr_i = 13'h0060; ins_word = 16'h6C00; ins_waits = 0; data_en = 1'b1;
    dat_we_i = 1'b0; dat_adr_i = 15'h0444; rd_word = 16'h4444; dat_waits = 255;
    ins_cyc_i = 1'b1; shr_stb_i = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 15'h0444)
      begin fails++; $display("FAIL mid_dacc: got cyc %b adr %h required cyc 1 adr 0444", wb_cyc_o, wb_adr_o); end
    rst_n = 1'b0;
    #1;
    tests_run += 3;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, shr_ack_o, err_o} !== 5'b0)
      begin fails++; $display("FAIL async_rst_ctrl: got %b required 00000", {wb_cyc_o, wb_stb_o, wb_we_o, shr_ack_o, err_o}); end
    if (wb_adr_o !== 15'h0 || ins_dat_o !== 16'h0 || dat_dat_o !== 16'h0)
      begin fails++; $display("FAIL async_rst_data: got adr %h ins %h dat %h required 0", wb_adr_o, ins_dat_o, dat_dat_o); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (shr_ack_o) seen = 1'b1;
    end
    if (seen !== 1'b0) begin fails++; $display("FAIL rst_no_ack: got %b required 0", seen); end
    shr_stb_i = 1'b0; ins_cyc_i = 1'b0;
    rst_n = 1'b1;
    model_err = 1'b0; model_dat = '0;
    @(negedge clk);
    drain_obs();
    do_step(13'h0070, 16'h6C00, 0, 1'b1, 1'b0, 15'h0555, 16'h0, 16'h7777, 0);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_load();
    test_store_wait();
    test_prog_seg();
    test_back_to_back();
    test_watchdog();
    test_stb_drop();
    test_reset_mid_dacc();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
